// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline control block.
// State codes, counter width and memory timeout defaults.
package pipeline_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HAZ  = 2'd1,
    S_MEMW = 2'd2,
    S_BR   = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW match and per-cycle action priority.
// Ports: ID sources, EX/MEM dests, busy/branch in; one-hot act + controls out.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       id_src1_i,
  input  logic [3:0] src1_i,
  input  logic [3:0] src2_i,
  input  logic       use_src2_i,
  input  logic [3:0] exe_dest_i,
  input  logic       exe_wb_en_i,
  input  logic       exe_mem_r_en_i,
  input  logic [3:0] mem_dest_i,
  input  logic       mem_wb_en_i,
  input  logic       fwd_en_i,
  input  logic       branch_taken_i,
  input  logic       br_pend_i,
  input  logic       mem_busy_i,
  output logic       do_busy_o,
  output logic       do_br_o,
  output logic       do_haz_o,
  output logic       freeze_if_o,
  output logic       freeze_if_id_o,
  output logic       freeze_ex_mem_o,
  output logic       flush_if_id_o,
  output logic       flush_id_ex_o
);

  logic ex_m, mem_m, haz, br;

  assign ex_m = exe_wb_en_i &&
    (src1_i == exe_dest_i ||
     (use_src2_i && src2_i == exe_dest_i));

  assign mem_m = mem_wb_en_i &&
    (src1_i == mem_dest_i ||
     (use_src2_i && src2_i == mem_dest_i));

  // With forwarding only a load in EX
  // cannot be bypassed in time.
  assign haz = fwd_en_i ? (ex_m && exe_mem_r_en_i)
                        : (ex_m || mem_m);

  assign br = branch_taken_i | br_pend_i;

  // Priority resolved here so the
  // decoder below sees a one-hot select.
  assign do_busy_o = mem_busy_i;
  assign do_br_o   = br & ~mem_busy_i;
  assign do_haz_o  = haz & ~br & ~mem_busy_i;

  always_comb begin
    freeze_if_o     = 1'b0;
    freeze_if_id_o  = 1'b0;
    freeze_ex_mem_o = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    unique case (1'b1)
      do_busy_o: begin
        freeze_if_o     = 1'b1;
        freeze_if_id_o  = 1'b1;
        freeze_ex_mem_o = 1'b1;
      end
      do_br_o: begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
      do_haz_o: begin
        freeze_if_o    = 1'b1;
        freeze_if_id_o = 1'b1;
        flush_id_ex_o  = 1'b1;
      end
      default: ;
    endcase
  end

  logic unused;
  assign unused = id_src1_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline freeze/flush control FSM with perf counters.
// Ports: hazard/branch/busy in; freeze/flush, state, mem_err, counts out.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src2,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             freeze_if,
  output logic             freeze_if_id,
  output logic             freeze_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BMAX = BW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic             mem_err_q, mem_err_d;
  logic [BW-1:0]    busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic do_busy, do_br, do_haz;
  logic f_if, f_ifid, f_exmem;
  logic fl_ifid, fl_idex;

  hazard_detect u_hd (
    .id_src1_i       (1'b0),
    .src1_i          (id_src1),
    .src2_i          (id_src2),
    .use_src2_i      (id_use_src2),
    .exe_dest_i      (exe_dest),
    .exe_wb_en_i     (exe_wb_en),
    .exe_mem_r_en_i  (exe_mem_r_en),
    .mem_dest_i      (mem_dest),
    .mem_wb_en_i     (mem_wb_en),
    .fwd_en_i        (fwd_en),
    .branch_taken_i  (branch_taken),
    .br_pend_i       (br_pend_q),
    .mem_busy_i      (mem_busy),
    .do_busy_o       (do_busy),
    .do_br_o         (do_br),
    .do_haz_o        (do_haz),
    .freeze_if_o     (f_if),
    .freeze_if_id_o  (f_ifid),
    .freeze_ex_mem_o (f_exmem),
    .flush_if_id_o   (fl_ifid),
    .flush_id_ex_o   (fl_idex)
  );

  // Controls are forced quiet while reset is held.
  assign freeze_if     = rst & f_if;
  assign freeze_if_id  = rst & f_ifid;
  assign freeze_ex_mem = rst & f_exmem;
  assign flush_if_id   = rst & fl_ifid;
  assign flush_id_ex   = rst & fl_idex;

  assign state     = state_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  always_comb begin
    state_d   = S_RUN;
    br_pend_d = br_pend_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    unique case (1'b1)
      do_busy: begin
        state_d   = S_MEMW;
        // Branch seen while frozen is replayed later.
        br_pend_d = br_pend_q | branch_taken;
      end
      do_br: begin
        state_d   = S_BR;
        br_pend_d = 1'b0;
        if (flush_q != CMAX)
          flush_d = flush_q + 1'b1;
      end
      do_haz: begin
        state_d = S_HAZ;
        if (stall_q != CMAX)
          stall_d = stall_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = '0;
    if (mem_busy)
      busy_d = (busy_q == BMAX) ? busy_q
                                : busy_q + 1'b1;
    mem_err_d = mem_err_q | (busy_d == BMAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_RUN;
      br_pend_q <= 1'b0;
      mem_err_q <= 1'b0;
      busy_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      mem_err_q <= mem_err_d;
      busy_q    <= busy_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
// Small params (timeout 4, 4-bit counters) to reach boundaries fast.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_use_src2, exe_wb_en, exe_mem_r_en;
  logic       mem_wb_en, fwd_en, branch_taken, mem_busy;
  logic       freeze_if, freeze_if_id, freeze_ex_mem;
  logic       flush_if_id, flush_id_ex, mem_err;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  logic [4:0] ctl;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11001;
  localparam logic [4:0] C_BUSY = 5'b11100;
  localparam logic [4:0] C_BR   = 5'b00011;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_use_src2   (id_use_src2),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_r_en  (exe_mem_r_en),
    .mem_dest      (mem_dest),
    .mem_wb_en     (mem_wb_en),
    .fwd_en        (fwd_en),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .freeze_if     (freeze_if),
    .freeze_if_id  (freeze_if_id),
    .freeze_ex_mem (freeze_ex_mem),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .state         (state),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  assign ctl = {freeze_if, freeze_if_id, freeze_ex_mem,
                flush_if_id, flush_id_ex};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src2 = 1'b0;
    exe_dest = 4'd9; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd9; mem_wb_en = 1'b0; fwd_en = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic settle(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, 32'(ctl), 32'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    mem_busy = 1'b1;
    branch_taken = 1'b1;
    settle("rst_ctl_quiet", C_NONE);
    cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    rst = 1'b1;
    idle();
    settle("idle_ctl", C_NONE);
    cyc();
    chk("idle_state", 32'(state), 32'd0);

    // RAW on EX, no forwarding
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    settle("raw_ex_ctl", C_HAZ);
    cyc();
    chk("raw_ex_state", 32'(state), 32'd1);
    chk("raw_ex_stall", 32'(stall_cnt), 32'd1);

    // same dest but WB disabled
    exe_wb_en = 1'b0;
    settle("raw_nowb_ctl", C_NONE);

    // MEM match on src2, gated by use_src2
    id_src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1;
    settle("src2_ungated_ctl", C_NONE);
    id_use_src2 = 1'b1;
    settle("src2_mem_ctl", C_HAZ);
    cyc();
    chk("src2_mem_stall", 32'(stall_cnt), 32'd2);

    // forwarding hides MEM match
    fwd_en = 1'b1;
    settle("fwd_mem_ctl", C_NONE);
    cyc();
    chk("fwd_mem_state", 32'(state), 32'd0);

    // forwarding: ALU result in EX, no stall
    idle();
    fwd_en = 1'b1;
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    settle("fwd_alu_ctl", C_NONE);
    cyc();
    chk("fwd_alu_stall", 32'(stall_cnt), 32'd2);

    // forwarding: load in EX, one bubble
    exe_mem_r_en = 1'b1;
    settle("fwd_ld_ctl", C_HAZ);
    cyc();
    chk("fwd_ld_state", 32'(state), 32'd1);
    chk("fwd_ld_stall", 32'(stall_cnt), 32'd3);
    exe_mem_r_en = 1'b0;
    settle("fwd_ld_after_ctl", C_NONE);
    cyc();

    // branch beats hazard
    idle();
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    branch_taken = 1'b1;
    settle("br_haz_ctl", C_BR);
    cyc();
    chk("br_haz_state", 32'(state), 32'd3);
    chk("br_haz_flush", 32'(flush_cnt), 32'd1);
    chk("br_haz_stall", 32'(stall_cnt), 32'd3);
    idle();
    settle("post_br_ctl", C_NONE);
    cyc();

    // branch while busy, 3 busy cycles
    mem_busy = 1'b1; branch_taken = 1'b1;
    settle("bb_c1_ctl", C_BUSY);
    cyc();
    chk("bb_c1_state", 32'(state), 32'd2);
    branch_taken = 1'b0;
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    settle("bb_c2_ctl", C_BUSY);
    cyc();
    idle();
    mem_busy = 1'b1;
    settle("bb_c3_ctl", C_BUSY);
    cyc();
    chk("bb_c3_flush", 32'(flush_cnt), 32'd1);
    chk("bb_c3_stall", 32'(stall_cnt), 32'd3);
    chk("bb_c3_err", 32'(mem_err), 32'd0);
    mem_busy = 1'b0;
    settle("bb_rel_ctl", C_BR);
    cyc();
    chk("bb_rel_state", 32'(state), 32'd3);
    chk("bb_rel_flush", 32'(flush_cnt), 32'd2);
    settle("bb_done_ctl", C_NONE);
    cyc();
    chk("bb_done_state", 32'(state), 32'd0);

    // repeated branch during busy counts once
    mem_busy = 1'b1; branch_taken = 1'b1;
    cyc();
    cyc();
    mem_busy = 1'b0; branch_taken = 1'b0;
    settle("rep_rel_ctl", C_BR);
    cyc();
    chk("rep_flush", 32'(flush_cnt), 32'd3);
    settle("rep_done_ctl", C_NONE);
    cyc();

    // timeout after 4 busy cycles
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("to_3_err", 32'(mem_err), 32'd0);
    cyc();
    chk("to_4_err", 32'(mem_err), 32'd1);
    mem_busy = 1'b0;
    cyc();
    chk("to_sticky_err", 32'(mem_err), 32'd1);
    chk("to_state", 32'(state), 32'd0);

    // reset mid-MEMW drops pending branch
    mem_busy = 1'b1; branch_taken = 1'b1;
    cyc();
    chk("rm_state", 32'(state), 32'd2);
    branch_taken = 1'b0;
    rst = 1'b0;
    settle("rm_ctl", C_NONE);
    cyc();
    chk("rm_rst_state", 32'(state), 32'd0);
    chk("rm_rst_err", 32'(mem_err), 32'd0);
    chk("rm_rst_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b1;
    idle();
    settle("rm_noflush_ctl", C_NONE);
    cyc();
    chk("rm_after_state", 32'(state), 32'd0);
    chk("rm_after_flush", 32'(flush_cnt), 32'd0);

    // stall counter saturation
    id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    chk("sat_state", 32'(state), 32'd1);
    settle("sat_ctl", C_HAZ);

    // flush counter saturation
    idle();
    branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    chk("sat_flush", 32'(flush_cnt), 32'd15);
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: mem_busy cycles before mem_err is set.
REQ-002 SHALL have parameter CNT_W, default 16: width of the saturating performance counters.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 id_src1  in  4  Rn index of the instruction in ID.
REQ-006 id_src2  in  4  Rm/Rd index of the instruction in ID; compared only when id_use_src2=1.
REQ-007 id_use_src2  in  1  ID instruction reads a second register.
REQ-008 exe_dest, exe_wb_en, exe_mem_r_en  in  4/1/1  ID/EX register outputs (Dest, WB_EN, MEM_R_EN).
REQ-009 mem_dest, mem_wb_en  in  4/1  EX/MEM register destination and write-back enable.
REQ-010 fwd_en  in  1  forwarding unit enabled.
REQ-011 branch_taken  in  1  B bit from the ID/EX register (branch resolved in EX).
REQ-012 mem_busy  in  1  data memory not ready this cycle.
REQ-013 freeze_if, freeze_if_id, freeze_ex_mem  out  1 each  hold PC, IF/ID and EX/MEM+MEM/WB registers.
REQ-014 flush_if_id, flush_id_ex  out  1 each  clear IF/ID and ID/EX registers (flush_id_ex drives the ID/EX register flush input).
REQ-015 state  out  2  current FSM state code.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating counts of hazard-stall cycles and branch flushes.

Function
REQ-018 Hazard (combinational): match = src equals dest with that stage's wb_en=1 (src2 gated by id_use_src2); fwd_en=0 -> hazard on any EX or MEM match; fwd_en=1 -> hazard only on an EX match with exe_mem_r_en=1.
REQ-019 FSM states SHALL be RUN=0, HAZ=1, MEMW=2, BR=3.
REQ-020 Per-cycle priority SHALL be mem_busy > branch (branch_taken or br_pend) > hazard > none.
REQ-021 mem_busy=1: freeze_if=freeze_if_id=freeze_ex_mem=1, both flushes 0, next state MEMW; in the same cycle, branch_taken=1 SHALL set br_pend.
REQ-022 Branch with mem_busy=0: flush_if_id=flush_id_ex=1, all freezes 0, br_pend cleared, flush_cnt+1, next state BR.
REQ-023 Hazard, with no branch and mem_busy=0: freeze_if=freeze_if_id=1, flush_id_ex=1 (bubble), freeze_ex_mem=0, stall_cnt+1, next state HAZ.
REQ-024 No condition: all control outputs 0, next state RUN.
REQ-025 Control outputs SHALL be combinational from the current inputs and br_pend, with zero cycle latency; state, br_pend, counters and mem_err SHALL be registered.
REQ-026 br_pend set during MEMW SHALL cause the branch flush in the first cycle mem_busy=0, even if branch_taken=0 then; a branch_taken repeated during MEMW SHALL count once.
REQ-027 A mem_busy run counter SHALL increment each cycle mem_busy=1 and clear when mem_busy=0; reaching MEM_TIMEOUT SHALL set mem_err, which stays set until reset.
REQ-028 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 A flush and a freeze of the same register SHALL never be asserted together.

Reset
REQ-030 rst=0 at a clock edge SHALL set state=RUN, br_pend=0, mem_err=0, counters=0 and the busy-run counter=0.
REQ-031 While rst=0, all freeze and flush outputs SHALL be 0.
REQ-032 Reset mid-MEMW SHALL discard any pending branch.

Structure
REQ-033 State encodings, the CNT_W default and the MEM_TIMEOUT default SHALL live in the shared package pipeline_pkg.
REQ-034 The match/priority logic SHALL be one sub-module, hazard_detect, which is purely combinational; the FSM and counters SHALL be in pipeline_ctrl.

Verification
REQ-035 RAW, no forwarding: fwd_en=0, id_src1=3, exe_dest=3, exe_wb_en=1 -> freeze_if=freeze_if_id=flush_id_ex=1, state=HAZ next, stall_cnt=1.
REQ-036 Forwarding: fwd_en=1, same match with exe_mem_r_en=0 -> no stall; with exe_mem_r_en=1 -> exactly one bubble cycle.
REQ-037 Branch over hazard: branch_taken=1 with a hazard present -> flush_if_id=flush_id_ex=1, freeze_if=0, flush_cnt=1, stall_cnt unchanged.
REQ-038 Branch while busy: mem_busy=1 for 3 cycles with branch_taken pulsed in cycle 1 -> all freezes for 3 cycles, then one flush cycle; flush_cnt=1.
REQ-039 Timeout: MEM_TIMEOUT=4, mem_busy held high -> mem_err=1 after the 4th busy cycle and stays 1 after mem_busy drops.
REQ-040 Reset and saturation: rst=0 during MEMW with br_pend=1 -> RUN, no flush afterwards; CNT_W=4 with 20 hazard cycles -> stall_cnt=15.
